// File: rtl/qpix_readback_rx.sv
// qpix_readback_rx: read-back deserializer for the QPix serial configuration interface.
// Generates gated CLKin pulses from a flop, samples the synchronized ASIC sdo line at the end
// of each high phase and assembles an MSB-first word presented with a one-cycle valid strobe.
// Optional feature macro: READBACK_PARITY_EN (one extra pulse captures an even-parity bit and
// drives parity_err).
module qpix_readback_rx #(
    parameter int unsigned CLK_DIV = 25,
    parameter int unsigned NBITS   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             single,
    input  logic             abort,
    input  logic             cnt_mode,
    input  logic             sdo,
    output logic             clkin_out,
    output logic             cnt_sel_out,
    output logic             busy,
    output logic [NBITS-1:0] data_out,
    output logic             data_valid,
`ifdef READBACK_PARITY_EN
    output logic             parity_err,
`endif
    output logic [5:0]       bit_cnt
);

`ifdef READBACK_PARITY_EN
    localparam int unsigned NPULSE = NBITS + 1;
`else
    localparam int unsigned NPULSE = NBITS;
`endif
    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] DivLast = CW'(CLK_DIV - 1);
    localparam logic [5:0] NPulse6 = 6'(NPULSE);

    typedef enum logic [1:0] {StIdle, StLow, StHigh, StDone} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     div_cnt_q, div_cnt_d;
    logic              burst_q, burst_d;
    logic [5:0]        bit_cnt_q, bit_cnt_d;
    logic [NBITS-1:0]  shift_q, shift_d;
    logic [NBITS-1:0]  data_q, data_d;
    logic              dv_q, dv_d;
    logic              clkin_q;
    logic              cnt_sel_q;
    logic              start_q, single_q;
    logic              sdo_meta_q, sdo_sync_q;
`ifdef READBACK_PARITY_EN
    logic              par_q, par_d;
    logic              perr_q, perr_d;
`endif

    logic start_rise, single_rise, last_tick;

    assign start_rise  = start & ~start_q;
    assign single_rise = single & ~single_q;
    assign last_tick   = (div_cnt_q == DivLast);

    // Next-state: pulse sequencing, capture on the final high cycle, abort has top priority.
    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        burst_d   = burst_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        dv_d      = 1'b0;
`ifdef READBACK_PARITY_EN
        par_d     = par_q;
        perr_d    = perr_q;
`endif
        if (abort) begin
            state_d   = StIdle;
            div_cnt_d = '0;
            burst_d   = 1'b0;
            bit_cnt_d = '0;
            shift_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // start wins over a same-cycle single
                    if (start_rise) begin
                        state_d   = StLow;
                        burst_d   = 1'b1;
                        bit_cnt_d = '0;
                        div_cnt_d = '0;
                    end else if (single_rise) begin
                        state_d   = StLow;
                        burst_d   = 1'b0;
                        div_cnt_d = '0;
                    end
                end
                StLow: begin
                    if (last_tick) begin
                        state_d   = StHigh;
                        div_cnt_d = '0;
                    end else begin
                        div_cnt_d = div_cnt_q + CW'(1);
                    end
                end
                StHigh: begin
                    if (last_tick) begin
                        div_cnt_d = '0;
                        if (!burst_q) begin
                            state_d = StIdle;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 6'd1;
`ifdef READBACK_PARITY_EN
                            // trailing pulse carries the parity bit, not data
                            if (bit_cnt_q == 6'(NBITS)) par_d = sdo_sync_q;
                            else shift_d = {shift_q[NBITS-2:0], sdo_sync_q};
`else
                            shift_d = {shift_q[NBITS-2:0], sdo_sync_q};
`endif
                            state_d = (bit_cnt_d == NPulse6) ? StDone : StLow;
                        end
                    end else begin
                        div_cnt_d = div_cnt_q + CW'(1);
                    end
                end
                StDone: begin
                    data_d  = shift_q;
                    dv_d    = 1'b1;
                    state_d = StIdle;
`ifdef READBACK_PARITY_EN
                    perr_d  = (^shift_q) ^ par_q;
`endif
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State and datapath registers; clkin_out is a pure flop output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            div_cnt_q  <= '0;
            burst_q    <= 1'b0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            dv_q       <= 1'b0;
            clkin_q    <= 1'b0;
            cnt_sel_q  <= 1'b0;
            start_q    <= 1'b0;
            single_q   <= 1'b0;
            sdo_meta_q <= 1'b0;
            sdo_sync_q <= 1'b0;
`ifdef READBACK_PARITY_EN
            par_q      <= 1'b0;
            perr_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            burst_q    <= burst_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            dv_q       <= dv_d;
            clkin_q    <= (state_d == StHigh);
            cnt_sel_q  <= cnt_mode;
            start_q    <= start;
            single_q   <= single;
            sdo_meta_q <= sdo;
            sdo_sync_q <= sdo_meta_q;
`ifdef READBACK_PARITY_EN
            par_q      <= par_d;
            perr_q     <= perr_d;
`endif
        end
    end

    assign clkin_out   = clkin_q;
    assign cnt_sel_out = cnt_sel_q;
    assign busy        = (state_q != StIdle);
    assign data_out    = data_q;
    assign data_valid  = dv_q;
    assign bit_cnt     = bit_cnt_q;
`ifdef READBACK_PARITY_EN
    assign parity_err  = perr_q;
`endif

endmodule

// File: tb/tb_qpix_readback_rx.sv
// Self-checking bench for qpix_readback_rx: an ASIC model shifts a word out MSB first on each
// CLKin rise; expected words, pulse counts and latency come from the behavioural rules.
module tb_qpix_readback_rx;

    localparam int CLK_DIV = 25;
    localparam int NBITS   = 32;
`ifdef READBACK_PARITY_EN
    localparam int NPULSE = NBITS + 1;
`else
    localparam int NPULSE = NBITS;
`endif
    localparam int LAT = 2 + 2 * CLK_DIV * NPULSE;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             single = 1'b0;
    logic             abort = 1'b0;
    logic             cnt_mode = 1'b0;
    logic             sdo;
    logic             clkin_out;
    logic             cnt_sel_out;
    logic             busy;
    logic [NBITS-1:0] data_out;
    logic             data_valid;
    logic [5:0]       bit_cnt;
`ifdef READBACK_PARITY_EN
    logic             parity_err;
`endif

    qpix_readback_rx #(.CLK_DIV(CLK_DIV), .NBITS(NBITS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .single     (single),
        .abort      (abort),
        .cnt_mode   (cnt_mode),
        .sdo        (sdo),
        .clkin_out  (clkin_out),
        .cnt_sel_out(cnt_sel_out),
        .busy       (busy),
        .data_out   (data_out),
        .data_valid (data_valid),
`ifdef READBACK_PARITY_EN
        .parity_err (parity_err),
`endif
        .bit_cnt    (bit_cnt)
    );

    always #10 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // ASIC model and observers
    logic [NBITS-1:0] tx_word = '0;
    logic             tx_par = 1'b0;
    int               tx_base = 0;
    int               pulse_total = 0;
    int               width_bad_total = 0;
    int               dv_total = 0;

    // reference: last word the DUT should present on data_out
    logic [NBITS-1:0] model_data = '0;

    // results of the last run_burst
    int lat, d_pulses, d_dv, d_wbad;

    // ASIC side: present the next word bit on each CLKin rise, count pulses and high widths.
    initial begin
        logic seen_hi;
        int   hi_len;
        int   idx;
        seen_hi = 1'b0;
        hi_len  = 0;
        sdo     = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (clkin_out && !seen_hi) begin
                pulse_total++;
                idx = pulse_total - tx_base;
                if (idx >= 1 && idx <= NBITS) sdo = tx_word[NBITS-idx];
                else sdo = tx_par;
                hi_len = 0;
            end
            if (clkin_out) hi_len++;
            if (!clkin_out && seen_hi && hi_len != CLK_DIV) width_bad_total++;
            if (data_valid) dv_total++;
            seen_hi = clkin_out;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Pulse start, wait (bounded) for data_valid; lat is -1 on timeout.
    task automatic run_burst(input logic [NBITS-1:0] word, input logic par);
        int p0, dv0, wb0;
        bit found;
        tx_word = word;
        tx_par  = par;
        tx_base = pulse_total;
        p0 = pulse_total; dv0 = dv_total; wb0 = width_bad_total;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        found = 1'b0;
        while (!found && lat < LAT + 200) begin
            if (data_valid) found = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        if (!found) lat = -1;
        repeat (60) @(negedge clk);
        d_pulses = pulse_total - p0;
        d_dv     = dv_total - dv0;
        d_wbad   = width_bad_total - wb0;
    endtask

    task automatic test_reset();
        n_vec++; if (clkin_out !== 1'b0) begin n_err++; $display("FAIL reset_clkin: got %b want 0", clkin_out); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (data_out !== '0) begin n_err++; $display("FAIL reset_data: got %h want 0", data_out); end
        n_vec++; if (data_valid !== 1'b0) begin n_err++; $display("FAIL reset_dv: got %b want 0", data_valid); end
        n_vec++; if (bit_cnt !== 6'd0) begin n_err++; $display("FAIL reset_bitcnt: got %0d want 0", bit_cnt); end
        n_vec++; if (cnt_sel_out !== 1'b0) begin n_err++; $display("FAIL reset_cntsel: got %b want 0", cnt_sel_out); end
`ifdef READBACK_PARITY_EN
        n_vec++; if (parity_err !== 1'b0) begin n_err++; $display("FAIL reset_perr: got %b want 0", parity_err); end
`endif
    endtask

    task automatic test_capture(input logic [NBITS-1:0] word, input string tag);
        run_burst(word, ^word);
        model_data = word;
        n_vec++; if (lat !== LAT) begin n_err++; $display("FAIL %s_latency: got %0d want %0d", tag, lat, LAT); end
        n_vec++; if (d_pulses !== NPULSE) begin n_err++; $display("FAIL %s_pulses: got %0d want %0d", tag, d_pulses, NPULSE); end
        n_vec++; if (d_wbad !== 0) begin n_err++; $display("FAIL %s_width: got %0d bad pulses want 0", tag, d_wbad); end
        n_vec++; if (d_dv !== 1) begin n_err++; $display("FAIL %s_dv_count: got %0d want 1", tag, d_dv); end
        n_vec++; if (data_out !== model_data) begin n_err++; $display("FAIL %s_data: got %h want %h", tag, data_out, model_data); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL %s_busy_after: got %b want 0", tag, busy); end
    endtask

    task automatic test_single();
        int p0, dv0;
        p0 = pulse_total; dv0 = dv_total;
        single = 1'b1;
        repeat (1010) @(negedge clk);
        single = 1'b0;
        repeat (60) @(negedge clk);
        n_vec++; if (pulse_total - p0 !== 1) begin n_err++; $display("FAIL single_pulses: got %0d want 1", pulse_total - p0); end
        n_vec++; if (dv_total - dv0 !== 0) begin n_err++; $display("FAIL single_dv: got %0d want 0", dv_total - dv0); end
        n_vec++; if (data_out !== model_data) begin n_err++; $display("FAIL single_data: got %h want %h", data_out, model_data); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [NBITS-1:0] word;
        int p0, dv0, guard;
        bit got_dv;
        word = $urandom;
        tx_word = word; tx_par = ^word; tx_base = pulse_total;
        p0 = pulse_total; dv0 = dv_total;
        start = 1'b1;
        guard = 0;
        while (pulse_total - p0 < 5 && guard < LAT) begin @(negedge clk); guard++; end
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        single = 1'b1;
        got_dv = 1'b0;
        guard = 0;
        while (!got_dv && guard < LAT + 200) begin
            @(negedge clk); guard++;
            if (data_valid) got_dv = 1'b1;
        end
        repeat (200) @(negedge clk);
        start = 1'b0;
        single = 1'b0;
        repeat (200) @(negedge clk);
        model_data = word;
        n_vec++; if (!got_dv) begin n_err++; $display("FAIL b2b_timeout: got no data_valid want one"); end
        n_vec++; if (pulse_total - p0 !== NPULSE) begin n_err++; $display("FAIL b2b_pulses: got %0d want %0d", pulse_total - p0, NPULSE); end
        n_vec++; if (dv_total - dv0 !== 1) begin n_err++; $display("FAIL b2b_dv: got %0d want 1", dv_total - dv0); end
        n_vec++; if (data_out !== model_data) begin n_err++; $display("FAIL b2b_data: got %h want %h", data_out, model_data); end
    endtask

    task automatic test_abort();
        int dv0, guard;
        dv0 = dv_total;
        tx_word = 32'h12345678; tx_par = ^tx_word; tx_base = pulse_total;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (!(bit_cnt == 6'd17 && clkin_out) && guard < LAT) begin @(negedge clk); guard++; end
        n_vec++; if (guard >= LAT) begin n_err++; $display("FAIL abort_reach17: got timeout want bit_cnt 17"); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_vec++; if (clkin_out !== 1'b0) begin n_err++; $display("FAIL abort_clkin: got %b want 0", clkin_out); end
        n_vec++; if (bit_cnt !== 6'd0) begin n_err++; $display("FAIL abort_bitcnt: got %0d want 0", bit_cnt); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", busy); end
        repeat (100) @(negedge clk);
        n_vec++; if (dv_total - dv0 !== 0) begin n_err++; $display("FAIL abort_dv: got %0d want 0", dv_total - dv0); end
        n_vec++; if (data_out !== model_data) begin n_err++; $display("FAIL abort_data: got %h want %h", data_out, model_data); end
        // abort beats a same-cycle start
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_vs_start: got busy %b want 0", busy); end
        repeat (5) @(negedge clk);
        test_capture(32'h12345678, "abort_recapture");
    endtask

    task automatic test_async_reset();
        int guard, p0;
        cnt_mode = 1'b1;
        tx_word = $urandom; tx_base = pulse_total;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (!(bit_cnt == 6'd3 && clkin_out) && guard < LAT) begin @(negedge clk); guard++; end
        #3;
        rst_n = 1'b0;
        #1;
        test_reset();
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_data = '0;
        p0 = pulse_total;
        repeat (100) @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_no_retrigger: got busy %b want 0", busy); end
        n_vec++; if (pulse_total - p0 !== 0) begin n_err++; $display("FAIL rst_no_pulses: got %0d want 0", pulse_total - p0); end
        test_capture($urandom, "post_reset");
    endtask

    task automatic test_cnt_sel();
        logic prev;
        for (int i = 0; i < 16; i++) begin
            prev = cnt_mode;
            cnt_mode = 1'($urandom_range(0, 1));
            @(negedge clk);
            n_vec++; if (cnt_sel_out !== cnt_mode) begin n_err++; $display("FAIL cnt_sel[%0d]: got %b want %b", i, cnt_sel_out, cnt_mode); end
            n_vec++; if (i > 0 && prev !== cnt_mode && cnt_sel_out === prev) begin n_err++; $display("FAIL cnt_sel_lag[%0d]: got %b want %b", i, cnt_sel_out, cnt_mode); end
        end
    endtask

`ifdef READBACK_PARITY_EN
    task automatic test_parity();
        run_burst(32'h00000001, 1'b1);
        model_data = 32'h00000001;
        n_vec++; if (d_pulses !== NBITS + 1) begin n_err++; $display("FAIL par1_pulses: got %0d want %0d", d_pulses, NBITS + 1); end
        n_vec++; if (parity_err !== 1'b0) begin n_err++; $display("FAIL par1_err: got %b want 0", parity_err); end
        n_vec++; if (data_out !== model_data) begin n_err++; $display("FAIL par1_data: got %h want %h", data_out, model_data); end
        run_burst(32'h00000001, 1'b0);
        n_vec++; if (d_pulses !== NBITS + 1) begin n_err++; $display("FAIL par0_pulses: got %0d want %0d", d_pulses, NBITS + 1); end
        n_vec++; if (parity_err !== 1'b1) begin n_err++; $display("FAIL par0_err: got %b want 1", parity_err); end
        n_vec++; if (lat !== LAT) begin n_err++; $display("FAIL par0_latency: got %0d want %0d", lat, LAT); end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        test_capture(32'hA0A0A0AF, "capture");
        test_single();
        test_abort();
        for (int i = 0; i < 2; i++) test_capture($urandom, "random");
        test_back_to_back();
        test_cnt_sel();
        test_async_reset();
`ifdef READBACK_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
